// File: rtl/axi_regif_pkg.sv
// Shared constants, types and address decode helper for the AXI-Lite register array.
package axi_regif_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest address the decode helper handles; narrower buses are zero-extended.
  localparam int MAX_ADDR_W = 64;
  localparam int IDX_W      = MAX_ADDR_W - 2;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_rsp_t;

  // Word index of a byte address; the byte offset within the word is dropped.
  function automatic reg_idx_t addr_to_idx(input logic [MAX_ADDR_W-1:0] addr);
    return reg_idx_t'(addr >> 2);
  endfunction

endpackage

// File: rtl/axi_regif_wcapture.sv
// One-deep AW and W holding slots, filled independently and cleared together on commit.
module axi_regif_wcapture #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic              i_commit,
  output logic              o_aw_full,
  output logic [ADDR_W-1:0] o_aw_addr,
  output logic              o_w_full,
  output logic [31:0]       o_w_data,
  output logic [3:0]        o_w_strb
);

  logic              r_aw_full;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_full;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;

  logic w_aw_hs;
  logic w_w_hs;

  assign o_awready = i_ce & ~i_rst & ~r_aw_full;
  assign o_wready  = i_ce & ~i_rst & ~r_w_full;
  assign w_aw_hs   = i_awvalid & o_awready;
  assign w_w_hs    = i_wvalid & o_wready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else if (i_ce) begin
      // A commit needs both slots full, so it never coincides with a capture.
      if (w_aw_hs)       r_aw_full <= 1'b1;
      else if (i_commit) r_aw_full <= 1'b0;
      if (w_w_hs)        r_w_full  <= 1'b1;
      else if (i_commit) r_w_full  <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed while the
  // matching full flag is set, which is itself reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_aw_addr <= i_awaddr;
    if (w_w_hs) begin
      r_w_data <= i_wdata;
      r_w_strb <= i_wstrb;
    end
  end

  assign o_aw_full = r_aw_full;
  assign o_aw_addr = r_aw_addr;
  assign o_w_full  = r_w_full;
  assign o_w_data  = r_w_data;
  assign o_w_strb  = r_w_strb;

endmodule

// File: rtl/axi_regif_array.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers, RW or hardware-sourced RO per bit of RO_MASK.
module axi_regif_array
  import axi_regif_pkg::*;
#(
  parameter int                       NUM_REGS  = 8,
  parameter int                       ADDR_W    = 32,
  parameter logic [NUM_REGS-1:0]      RO_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0]   RESET_VAL = '0
) (
  input  logic                     aclk_s,
  input  logic                     areset_s,
  input  logic                     ce,
  input  logic [ADDR_W-1:0]        awaddr_s,
  input  logic [2:0]               awprot_s,
  input  logic                     awvalid_s,
  output logic                     awready_s,
  input  logic [31:0]              wdata_s,
  input  logic [3:0]               wstrb_s,
  input  logic                     wvalid_s,
  output logic                     wready_s,
  output logic [1:0]               bresp_s,
  output logic                     bvalid_s,
  input  logic                     bready_s,
  input  logic [ADDR_W-1:0]        araddr_s,
  input  logic [2:0]               arprot_s,
  input  logic                     arvalid_s,
  output logic                     arready_s,
  output logic [31:0]              rdata_s,
  output logic [1:0]               rresp_s,
  output logic                     rvalid_s,
  input  logic                     rready_s,
  output logic [NUM_REGS*32-1:0]   regs_o,
  input  logic [NUM_REGS*32-1:0]   regs_i,
  output logic [NUM_REGS-1:0]      wr_pulse_o,
  output logic [NUM_REGS-1:0]      rd_pulse_o
);

  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]       r_regs [NUM_REGS];
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  rd_rsp_t           r_rd;

  logic              w_active;
  logic              w_aw_full;
  logic [ADDR_W-1:0] w_aw_addr;
  logic              w_w_full;
  logic [31:0]       w_w_data;
  logic [3:0]        w_w_strb;
  logic              w_commit;
  reg_idx_t          w_aw_idx;
  logic [SEL_W-1:0]  w_aw_sel;
  logic              w_aw_mapped;
  logic              w_aw_rw;
  logic              w_wr_en;
  logic              w_ar_hs;
  reg_idx_t          w_ar_idx;
  logic [SEL_W-1:0]  w_ar_sel;
  logic              w_ar_mapped;
  rd_rsp_t           w_rd_rsp;
  logic [NUM_REGS-1:0] w_wr_pulse;
  logic [NUM_REGS-1:0] w_rd_pulse;
  logic              w_unused_prot;

  assign w_active      = ce & ~areset_s;
  assign w_unused_prot = ^{awprot_s, arprot_s};

  axi_regif_wcapture #(
    .ADDR_W (ADDR_W)
  ) u_wcapture (
    .clk       (aclk_s),
    .i_rst     (areset_s),
    .i_ce      (ce),
    .i_awaddr  (awaddr_s),
    .i_awvalid (awvalid_s),
    .o_awready (awready_s),
    .i_wdata   (wdata_s),
    .i_wstrb   (wstrb_s),
    .i_wvalid  (wvalid_s),
    .o_wready  (wready_s),
    .i_commit  (w_commit),
    .o_aw_full (w_aw_full),
    .o_aw_addr (w_aw_addr),
    .o_w_full  (w_w_full),
    .o_w_data  (w_w_data),
    .o_w_strb  (w_w_strb)
  );

  // Write decode: only a mapped, non-RO target changes state.
  assign w_aw_idx    = addr_to_idx(MAX_ADDR_W'(w_aw_addr));
  assign w_aw_mapped = w_aw_idx < reg_idx_t'(NUM_REGS);
  assign w_aw_sel    = w_aw_idx[SEL_W-1:0];
  assign w_aw_rw     = w_aw_mapped & ~RO_MASK[w_aw_sel];
  assign w_commit    = w_active & w_aw_full & w_w_full & ~r_bvalid;
  assign w_wr_en     = w_commit & w_aw_rw;

  always_ff @(posedge aclk_s) begin
    if (areset_s) begin
      // RO entries are held at zero so regs_o shows nothing in those lanes.
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
    end else if (w_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (w_w_strb[k]) r_regs[w_aw_sel][8*k +: 8] <= w_w_data[8*k +: 8];
    end
  end

  always_ff @(posedge aclk_s) begin
    if (areset_s) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (ce) begin
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_rw ? RESP_OKAY : RESP_SLVERR;
      end else if (bready_s) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read decode; r_regs is sampled before any same-cycle commit lands.
  assign arready_s   = w_active & ~r_rvalid;
  assign w_ar_hs     = arvalid_s & arready_s;
  assign w_ar_idx    = addr_to_idx(MAX_ADDR_W'(araddr_s));
  assign w_ar_mapped = w_ar_idx < reg_idx_t'(NUM_REGS);
  assign w_ar_sel    = w_ar_idx[SEL_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_rd_rsp = '{data: 32'h0, resp: RESP_SLVERR};
    if (w_ar_mapped) begin
      w_rd_rsp.resp = RESP_OKAY;
      w_rd_rsp.data = RO_MASK[w_ar_sel] ? regs_i[32*w_ar_sel +: 32] : r_regs[w_ar_sel];
    end
  end

  always_ff @(posedge aclk_s) begin
    if (areset_s) begin
      r_rvalid <= 1'b0;
      r_rd     <= '0;
    end else if (ce) begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rd     <= w_rd_rsp;
      end else if (rready_s) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_wr_pulse = '0;
    w_rd_pulse = '0;
    if (w_wr_en)               w_wr_pulse[w_aw_sel] = 1'b1;
    if (w_ar_hs & w_ar_mapped) w_rd_pulse[w_ar_sel] = 1'b1;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[32*g +: 32] = r_regs[g];
  end

  assign bvalid_s   = r_bvalid;
  assign bresp_s    = r_bresp;
  assign rvalid_s   = r_rvalid;
  assign rdata_s    = r_rd.data;
  assign rresp_s    = r_rd.resp;
  assign wr_pulse_o = w_wr_pulse;
  assign rd_pulse_o = w_rd_pulse;

endmodule

// File: tb/tb_axi_regif_array.sv
// Directed self-checking bench for axi_regif_array (8 registers, register 7 read-only).
module tb_axi_regif_array;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 32;
  localparam logic [7:0]   RO_MASK = 8'h80;
  localparam logic [255:0] RV = {32'hFFFF_FFFF, 32'h0606_0606, 32'h0505_0505, 32'h0404_0404,
                                 32'h0303_0303, 32'hCAFE_0002, 32'h0000_0000, 32'h0000_0001};
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         ce = 1'b1;
  logic [31:0]  awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [31:0]  araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [255:0] regs_o;
  logic [255:0] regs_i = {8{32'hA5A5_A5A5}};
  logic [7:0]   wr_pulse;
  logic [7:0]   rd_pulse;

  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_regs [NUM_REGS];

  always #5 clk = ~clk;

  axi_regif_array #(
    .NUM_REGS (NUM_REGS), .ADDR_W (ADDR_W), .RO_MASK (RO_MASK), .RESET_VAL (RV)
  ) dut (
    .aclk_s (clk), .areset_s (areset), .ce (ce),
    .awaddr_s (awaddr), .awprot_s (awprot), .awvalid_s (awvalid), .awready_s (awready),
    .wdata_s (wdata), .wstrb_s (wstrb), .wvalid_s (wvalid), .wready_s (wready),
    .bresp_s (bresp), .bvalid_s (bvalid), .bready_s (bready),
    .araddr_s (araddr), .arprot_s (arprot), .arvalid_s (arvalid), .arready_s (arready),
    .rdata_s (rdata), .rresp_s (rresp), .rvalid_s (rvalid), .rready_s (rready),
    .regs_o (regs_o), .regs_i (regs_i), .wr_pulse_o (wr_pulse), .rd_pulse_o (rd_pulse)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[32*i +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RO_MASK[i] ? 32'h0 : RV[32*i +: 32];
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("%s_reg%0d", tag, i), reg_of(i), exp_regs[i]);
  endtask

  task automatic wait_bvalid();
    int n = 0;
    while (!bvalid && n < 16) begin
      tick();
      n++;
    end
    if (!bvalid) check("b_timeout", 64'(bvalid), 64'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] pulse);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    #1 pulse = wr_pulse;
    wait_bvalid();
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output logic [7:0] pulse);
    araddr = addr; arvalid = 1'b1;
    #1 pulse = rd_pulse;
    tick();
    arvalid = 1'b0;
    check("r_latency", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;

    model_reset();
    // Reset: readies low while asserted, then clean idle state.
    tick(); tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    tick();
    areset = 1'b0;
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_pulses", 64'({wr_pulse, rd_pulse}), 64'd0);
    check_regs("rst");

    // AW first, W three cycles later.
    awaddr = 32'h04; awvalid = 1'b1;
    #1 check("aw1_ready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    check("aw1_full", 64'(awready), 64'd0);
    tick(); tick();
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    #1 check("w1_ready", 64'(wready), 64'd1);
    check("w1_nopulse", 64'(wr_pulse), 64'd0);
    tick();
    wvalid = 1'b0;
    check("w1_commit_pulse", 64'(wr_pulse), 64'h02);
    check("w1_bvalid_lo", 64'(bvalid), 64'd0);
    tick();
    check("w1_bvalid", 64'(bvalid), 64'd1);
    check("w1_bresp", 64'(bresp), 64'(OKAY));
    check("w1_pulse_off", 64'(wr_pulse), 64'd0);
    exp_regs[1] = 32'h1234_5678;
    check("w1_reg1", 64'(reg_of(1)), 64'(exp_regs[1]));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("w1_bdone", 64'(bvalid), 64'd0);

    // Byte-lane strobes.
    do_write(32'h04, 32'hAABB_CCDD, 4'b0101, resp, pulse);
    exp_regs[1] = 32'h12BB_56DD;
    check("w2_resp", 64'(resp), 64'(OKAY));
    check("w2_pulse", 64'(pulse), 64'h02);
    check("w2_reg1", 64'(reg_of(1)), 64'(exp_regs[1]));

    // Low address bits ignored: 0x0B selects register 2.
    do_write(32'h0B, 32'h1122_3344, 4'hF, resp, pulse);
    exp_regs[2] = 32'h1122_3344;
    check("w3_pulse", 64'(pulse), 64'h04);
    check("w3_reg2", 64'(reg_of(2)), 64'(exp_regs[2]));

    // RO read with stalled R channel; regs_i captured at handshake.
    regs_i[255:224] = 32'hDEAD_BEEF;
    araddr = 32'h1C; arvalid = 1'b1;
    #1 check("ro_arready", 64'(arready), 64'd1);
    check("ro_rd_pulse", 64'(rd_pulse), 64'h80);
    tick();
    arvalid = 1'b0;
    regs_i[255:224] = 32'h0123_4567;
    check("ro_rvalid", 64'(rvalid), 64'd1);
    check("ro_rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("ro_rresp", 64'(rresp), 64'(OKAY));
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ro_hold%0d", i), 64'({rvalid, arready, rresp, rdata}),
            64'({1'b1, 1'b0, OKAY, 32'hDEAD_BEEF}));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("ro_rdone", 64'(rvalid), 64'd0);

    // Write to RO register is rejected.
    do_write(32'h1C, 32'hFFFF_0000, 4'hF, resp, pulse);
    check("wro_resp", 64'(resp), 64'(SLVERR));
    check("wro_pulse", 64'(pulse), 64'd0);
    check("wro_reg7", 64'(reg_of(7)), 64'd0);

    // Unmapped write and read.
    do_write(32'h20, 32'h9999_9999, 4'hF, resp, pulse);
    check("wum_resp", 64'(resp), 64'(SLVERR));
    check("wum_pulse", 64'(pulse), 64'd0);
    check_regs("wum");
    do_read(32'h20, data, resp, pulse);
    check("rum_resp", 64'(resp), 64'(SLVERR));
    check("rum_data", 64'(data), 64'd0);
    check("rum_pulse", 64'(pulse), 64'd0);

    // RW read returns register, not regs_i.
    do_read(32'h04, data, resp, pulse);
    check("rrw_data", 64'(data), 64'h12BB_56DD);
    check("rrw_resp", 64'(resp), 64'(OKAY));
    check("rrw_pulse", 64'(pulse), 64'h02);

    // AW, W and AR to register 0 in the same cycle.
    awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h0; arvalid = 1'b1;
    #1 check("same_rd_pulse", 64'(rd_pulse), 64'h01);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_rdata", 64'(rdata), 64'h1);
    check("same_commit", 64'(wr_pulse), 64'h01);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    exp_regs[0] = 32'h2;
    check("same_reg0", 64'(reg_of(0)), 64'h2);
    check("same_bvalid", 64'(bvalid), 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Read handshake in the exact commit cycle returns the old value.
    awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h3; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0; arvalid = 1'b1;
    #1 check("coin_pulses", 64'({wr_pulse, rd_pulse}), 64'h0101);
    tick();
    arvalid = 1'b0;
    check("coin_rdata", 64'(rdata), 64'h2);
    exp_regs[0] = 32'h3;
    check("coin_reg0", 64'(reg_of(0)), 64'h3);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;

    // W before AW.
    wdata = 32'h0B0B_0B0B; wstrb = 4'hF; wvalid = 1'b1;
    #1 check("wfirst_wready", 64'(wready), 64'd1);
    tick();
    wvalid = 1'b0;
    check("wfirst_wfull", 64'(wready), 64'd0);
    check("wfirst_nopulse", 64'(wr_pulse), 64'd0);
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_pulse", 64'(wr_pulse), 64'h08);
    wait_bvalid();
    exp_regs[3] = 32'h0B0B_0B0B;
    check("wfirst_reg3", 64'(reg_of(3)), 64'(exp_regs[3]));
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Clock enable low freezes everything.
    awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h4444_0000; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; ce = 1'b0;
    arvalid = 1'b1; araddr = 32'h0;
    #1 check("ce0_pulses", 64'({wr_pulse, rd_pulse}), 64'd0);
    check("ce0_readies", 64'({awready, wready, arready}), 64'd0);
    tick(); tick();
    arvalid = 1'b0;
    check("ce0_bvalid", 64'(bvalid), 64'd0);
    check("ce0_rvalid", 64'(rvalid), 64'd0);
    check("ce0_reg4", 64'(reg_of(4)), 64'h0404_0404);
    ce = 1'b1;
    #1 check("ce1_pulse", 64'(wr_pulse), 64'h10);
    tick();
    exp_regs[4] = 32'h4444_0000;
    check("ce1_bvalid", 64'(bvalid), 64'd1);
    check("ce1_reg4", 64'(reg_of(4)), 64'(exp_regs[4]));
    ce = 1'b0; bready = 1'b1;
    tick();
    check("ce0_bhold", 64'(bvalid), 64'd1);
    ce = 1'b1;
    tick();
    bready = 1'b0;
    check("ce1_bdone", 64'(bvalid), 64'd0);

    // Reset with B pending and an AW held.
    awaddr = 32'h14; awvalid = 1'b1; wdata = 32'h5555_AAAA; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("mid_bvalid", 64'(bvalid), 64'd1);
    awaddr = 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_awfull", 64'(awready), 64'd0);
    areset = 1'b1;
    #1 check("mid_rst_readies", 64'({awready, wready, arready}), 64'd0);
    tick();
    areset = 1'b0;
    model_reset();
    check("post_bvalid", 64'(bvalid), 64'd0);
    check("post_rvalid", 64'(rvalid), 64'd0);
    check_regs("post");
    do_write(32'h14, 32'h0000_5A5A, 4'b0011, resp, pulse);
    exp_regs[5] = 32'h0505_5A5A;
    check("post_resp", 64'(resp), 64'(OKAY));
    check("post_pulse", 64'(pulse), 64'h20);
    check_regs("post_wr");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
